// File: rtl/voice_allocator_pkg.sv
// ============================================================================
// Module  : voice_allocator_pkg
// Brief   : Shared state encodings, event constants and helpers for the
//           voice allocator.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package voice_allocator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'b001,
        ST_STEAL_WAIT = 3'b010,
        ST_FREE_WAIT  = 3'b100
    } va_state_t;

    localparam logic EV_OFF = 1'b0;
    localparam logic EV_ON  = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/voice_allocator_pick.sv
// ============================================================================
// Module  : voice_pick
// Brief   : Combinational selector: lowest free voice and oldest held voice.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module voice_pick
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4,
    parameter int IDX_W      = idx_width(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]       held,
    input  logic [NUM_VOICES-1:0]       busy,
    input  logic [NUM_VOICES*AGE_W-1:0] age,
    output logic [IDX_W-1:0]            free_idx,
    output logic                        free_found,
    output logic [IDX_W-1:0]            old_idx,
    output logic                        old_found
);

    logic [AGE_W-1:0] w_best_age;

    // Strict '>' keeps the lowest index on equal ages.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        old_idx    = '0;
        old_found  = 1'b0;
        w_best_age = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!free_found && !held[i] && !busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (held[i] && (!old_found || (age[i*AGE_W +: AGE_W] > w_best_age))) begin
                old_found  = 1'b1;
                old_idx    = IDX_W'(i);
                w_best_age = age[i*AGE_W +: AGE_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================================
// Module  : voice_allocator
// Brief   : Polyphony controller assigning note events to envelope voices,
//           with oldest-voice stealing and wait-for-release.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int AGE_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]        voice_busy,
    output logic [NUM_VOICES-1:0]        voice_note_on,
    output logic [NUM_VOICES-1:0]        voice_note_off,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_held,
    output logic                         steal
);

    localparam int               IDX_W     = idx_width(NUM_VOICES);
    localparam logic [AGE_W-1:0] c_AGE_MAX = '1;

    va_state_t                   r_state, w_state_nxt;
    logic [NUM_VOICES-1:0]       r_held, w_held_nxt;
    logic [NUM_VOICES-1:0]       r_note_on, w_note_on_nxt;
    logic [NUM_VOICES-1:0]       r_note_off, w_note_off_nxt;
    logic                        r_steal, w_steal_nxt;
    logic [NUM_VOICES*NOTE_W-1:0] r_note, w_note_nxt;
    logic [NUM_VOICES*AGE_W-1:0] r_age, w_age_nxt;
    logic [IDX_W-1:0]            r_victim, w_victim_nxt;
    logic [NOTE_W-1:0]           r_pend_note, w_pend_nxt;

    logic                        w_alloc;
    logic [IDX_W-1:0]            w_alloc_idx;
    logic [IDX_W-1:0]            w_free_idx, w_old_idx, w_match_idx;
    logic                        w_free_found, w_old_found, w_match_found;
    logic                        w_is_on, w_is_off;

    voice_pick #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_pick (
        .held       (r_held),
        .busy       (voice_busy),
        .age        (r_age),
        .free_idx   (w_free_idx),
        .free_found (w_free_found),
        .old_idx    (w_old_idx),
        .old_found  (w_old_found)
    );

    assign w_is_on  = (ev_on == EV_ON);
    assign w_is_off = (ev_on == EV_OFF);

    always_comb begin
        w_match_found = 1'b0;
        w_match_idx   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_match_found && r_held[i] && (r_note[i*NOTE_W +: NOTE_W] == ev_note)) begin
                w_match_found = 1'b1;
                w_match_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_held_nxt     = r_held;
        w_note_on_nxt  = '0;
        w_note_off_nxt = '0;
        w_steal_nxt    = 1'b0;
        w_note_nxt     = r_note;
        w_age_nxt      = r_age;
        w_victim_nxt   = r_victim;
        w_pend_nxt     = r_pend_note;
        w_alloc        = 1'b0;
        w_alloc_idx    = '0;

        case (r_state)
            ST_IDLE: begin
                if (ev_valid) begin
                    if (w_is_off) begin
                        if (w_match_found) begin
                            w_note_off_nxt[w_match_idx] = 1'b1;
                            w_held_nxt[w_match_idx]     = 1'b0;
                        end
                    end else if (w_is_on && !w_match_found) begin
                        if (w_free_found) begin
                            w_alloc                                = 1'b1;
                            w_alloc_idx                            = w_free_idx;
                            w_note_on_nxt[w_free_idx]              = 1'b1;
                            w_held_nxt[w_free_idx]                 = 1'b1;
                            w_note_nxt[w_free_idx*NOTE_W +: NOTE_W] = ev_note;
                        end else if (w_old_found) begin
                            w_note_off_nxt[w_old_idx]              = 1'b1;
                            w_steal_nxt                            = 1'b1;
                            w_note_nxt[w_old_idx*NOTE_W +: NOTE_W] = ev_note;
                            w_victim_nxt                           = w_old_idx;
                            w_state_nxt                            = ST_STEAL_WAIT;
                        end else begin
                            w_pend_nxt  = ev_note;
                            w_state_nxt = ST_FREE_WAIT;
                        end
                    end
                end
            end
            ST_STEAL_WAIT: begin
                // r_steal marks the cycle the note_off is still on the wire; busy is ignored then.
                if (!r_steal && !voice_busy[r_victim]) begin
                    w_alloc                 = 1'b1;
                    w_alloc_idx             = r_victim;
                    w_note_on_nxt[r_victim] = 1'b1;
                    w_state_nxt             = ST_IDLE;
                end
            end
            ST_FREE_WAIT: begin
                if (w_free_found) begin
                    w_alloc                                = 1'b1;
                    w_alloc_idx                            = w_free_idx;
                    w_note_on_nxt[w_free_idx]              = 1'b1;
                    w_held_nxt[w_free_idx]                 = 1'b1;
                    w_note_nxt[w_free_idx*NOTE_W +: NOTE_W] = r_pend_note;
                    w_state_nxt                            = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_alloc) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == w_alloc_idx) begin
                    w_age_nxt[i*AGE_W +: AGE_W] = '0;
                end else if (r_held[i] && (r_age[i*AGE_W +: AGE_W] != c_AGE_MAX)) begin
                    w_age_nxt[i*AGE_W +: AGE_W] = r_age[i*AGE_W +: AGE_W] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_IDLE;
            r_held      <= '0;
            r_note_on   <= '0;
            r_note_off  <= '0;
            r_steal     <= 1'b0;
            r_note      <= '0;
            r_age       <= '0;
            r_victim    <= '0;
            r_pend_note <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_held      <= w_held_nxt;
            r_note_on   <= w_note_on_nxt;
            r_note_off  <= w_note_off_nxt;
            r_steal     <= w_steal_nxt;
            r_note      <= w_note_nxt;
            r_age       <= w_age_nxt;
            r_victim    <= w_victim_nxt;
            r_pend_note <= w_pend_nxt;
        end
    end

    assign ev_ready       = (r_state == ST_IDLE);
    assign voice_note_on  = r_note_on;
    assign voice_note_off = r_note_off;
    assign voice_note     = r_note;
    assign voice_held     = r_held;
    assign steal          = r_steal;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// Module  : tb_voice_allocator
// Brief   : Directed self-checking bench for voice_allocator (4 voices).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_voice_allocator;
    import voice_allocator_pkg::*;

    localparam int NV = 4;
    localparam int NW = 7;
    localparam int AW = 4;

    logic              clk;
    logic              rst_b;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [NW-1:0]     ev_note;
    logic [NV-1:0]     voice_busy;
    logic [NV-1:0]     voice_note_on;
    logic [NV-1:0]     voice_note_off;
    logic [NV*NW-1:0]  voice_note;
    logic [NV-1:0]     voice_held;
    logic              steal;

    int n_checks;
    int n_fail;

    voice_allocator #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW),
        .AGE_W      (AW)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_on          (ev_on),
        .ev_note        (ev_note),
        .voice_busy     (voice_busy),
        .voice_note_on  (voice_note_on),
        .voice_note_off (voice_note_off),
        .voice_note     (voice_note),
        .voice_held     (voice_held),
        .steal          (steal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one event for one cycle; returns in the cycle after acceptance.
    task automatic send_event(input logic on, input logic [NW-1:0] note);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = note;
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_b      = 1'b0;
        ev_valid   = 1'b0;
        voice_busy = '0;
        tick();
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    function automatic logic [NW-1:0] vnote(input int i);
        return voice_note[i*NW +: NW];
    endfunction

    initial begin
        logic [NV-1:0] acc_on;
        logic          acc_ready;
        logic [NW-1:0] notes4 [4];

        n_checks   = 0;
        n_fail     = 0;
        rst_b      = 1'b0;
        ev_valid   = 1'b0;
        ev_on      = 1'b0;
        ev_note    = '0;
        voice_busy = '0;
        notes4[0]  = 7'd60;
        notes4[1]  = 7'd62;
        notes4[2]  = 7'd64;
        notes4[3]  = 7'd65;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ev_ready), 64'd1);
        check("rst_outs", 64'({voice_note_on, voice_note_off, voice_held, steal}), 64'd0);
        check("rst_note", 64'(voice_note), 64'd0);
        rst_b = 1'b1;
        tick();

        // Three note-ons land on voices 0,1,2 back to back.
        for (int k = 0; k < 3; k++) begin
            check("alloc_ready", 64'(ev_ready), 64'd1);
            send_event(EV_ON, notes4[k]);
            check("alloc_on", 64'(voice_note_on), 64'(4'b0001 << k));
            check("alloc_off", 64'(voice_note_off), 64'd0);
            voice_busy[k] = 1'b1;
        end
        check("held_0111", 64'(voice_held), 64'b0111);
        check("note_v1", 64'(vnote(1)), 64'd62);
        check("note_v2", 64'(vnote(2)), 64'd64);

        send_event(EV_OFF, 7'd62);
        check("off62_pulse", 64'(voice_note_off), 64'b0010);
        check("off62_held", 64'(voice_held), 64'b0101);
        send_event(EV_OFF, 7'd99);
        check("off99_pulse", 64'(voice_note_off), 64'd0);
        check("off99_held", 64'(voice_held), 64'b0101);

        // Fresh start so the ages are 3,2,1,0 on voices 0..3.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_event(EV_ON, notes4[k]);
            check("fill_on", 64'(voice_note_on), 64'(4'b0001 << k));
            voice_busy[k] = 1'b1;
        end
        check("fill_held", 64'(voice_held), 64'b1111);

        send_event(EV_ON, 7'd67);
        check("steal_off", 64'(voice_note_off), 64'b0001);
        check("steal_pulse", 64'(steal), 64'd1);
        check("steal_noon", 64'(voice_note_on), 64'd0);
        check("steal_note", 64'(vnote(0)), 64'd67);
        check("steal_held", 64'(voice_held), 64'b1111);
        acc_on    = '0;
        acc_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            acc_ready = acc_ready | ev_ready;
            acc_on    = acc_on | voice_note_on;
            tick();
        end
        check("steal_wait_ready", 64'(acc_ready), 64'd0);
        check("steal_wait_on", 64'(acc_on), 64'd0);
        voice_busy[0] = 1'b0;
        tick();
        check("steal_done_on", 64'(voice_note_on), 64'b0001);
        check("steal_done_ready", 64'(ev_ready), 64'd1);
        check("steal_done_steal", 64'(steal), 64'd0);
        voice_busy[0] = 1'b1;
        tick();

        // Voice 1 is now oldest; its busy drops during the note_off cycle, which is ignored.
        send_event(EV_ON, 7'd69);
        check("steal2_off", 64'(voice_note_off), 64'b0010);
        check("steal2_pulse", 64'(steal), 64'd1);
        voice_busy[1] = 1'b0;
        tick();
        check("steal2_early", 64'(voice_note_on), 64'd0);
        tick();
        check("steal2_on", 64'(voice_note_on), 64'b0010);
        check("steal2_note", 64'(vnote(1)), 64'd69);
        voice_busy[1] = 1'b1;
        tick();

        send_event(EV_ON, 7'd64);
        check("dup_pulses", 64'({voice_note_on, voice_note_off, steal}), 64'd0);
        check("dup_held", 64'(voice_held), 64'b1111);
        check("dup_ready", 64'(ev_ready), 64'd1);
        check("dup_note", 64'(vnote(2)), 64'd64);

        // Release everything; voices stay busy so the next note-on must wait.
        send_event(EV_OFF, 7'd67);
        send_event(EV_OFF, 7'd69);
        send_event(EV_OFF, 7'd64);
        send_event(EV_OFF, 7'd65);
        check("rel_all_held", 64'(voice_held), 64'd0);
        send_event(EV_ON, 7'd70);
        check("fw_ready", 64'(ev_ready), 64'd0);
        check("fw_pulses", 64'({voice_note_on, voice_note_off, steal}), 64'd0);
        tick();
        tick();
        check("fw_ready2", 64'(ev_ready), 64'd0);
        voice_busy[2] = 1'b0;
        tick();
        check("fw_on", 64'(voice_note_on), 64'b0100);
        check("fw_note", 64'(vnote(2)), 64'd70);
        check("fw_held", 64'(voice_held), 64'b0100);
        check("fw_ready3", 64'(ev_ready), 64'd1);
        voice_busy[2] = 1'b1;
        tick();

        // Only voice 2 is held, others busy: steal, then reset mid-wait.
        send_event(EV_ON, 7'd71);
        check("rs_steal", 64'(steal), 64'd1);
        check("rs_off", 64'(voice_note_off), 64'b0100);
        tick();
        rst_b = 1'b0;
        #1;
        check("rs_async_outs", 64'({voice_note_on, voice_note_off, voice_held, steal}), 64'd0);
        check("rs_async_note", 64'(voice_note), 64'd0);
        check("rs_async_ready", 64'(ev_ready), 64'd1);
        voice_busy = '0;
        tick();
        tick();
        rst_b  = 1'b1;
        acc_on = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            acc_on = acc_on | voice_note_on;
        end
        check("rs_no_pending", 64'(acc_on), 64'd0);
        check("rs_ready", 64'(ev_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
